// File: rtl/mul_pipe_ctrl.sv
// RV32M multiply wrapper: decodes MUL/MULH/MULHSU/MULHU into magnitudes, drives the tree
// multiplier, restores sign and picks a word. Optional hi/lo fusion under MUL_HILO_FUSE_EN.

module mul #(
    parameter int W   = 32,
    parameter int TYP = 0
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    // Behavioural stand-in for the dadda/wallace trees; both reduce to the same product.
    generate
        if (TYP == 0) begin : g_dadda
            assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else begin : g_wallace
            assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    endgenerate
endmodule

module mul_pipe_ctrl #(
    parameter int XLEN    = 32,
    parameter int MUL_TYP = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);
    logic              s1_valid, s1_neg, s1_hi;
    logic [XLEN-1:0]   s1_a, s1_b;
    logic [2*XLEN-1:0] p, r_full;
    logic              sa_in, sb_in, s2_free, s1_adv, accept, fuse_hit, s1_load;
    logic [XLEN-1:0]   a_mag, b_mag;

    // MUL treats a as signed too: the low word is identical either way, and the sign
    // bits double as the fusion signedness tag.
    assign sa_in   = (op_i != 2'b11) & rs1_i[XLEN-1];
    assign sb_in   = (op_i == 2'b01) & rs2_i[XLEN-1];
    assign a_mag   = sa_in ? -rs1_i : rs1_i;
    assign b_mag   = sb_in ? -rs2_i : rs2_i;

    assign s2_free    = !out_valid_o | out_ready_i;
    assign s1_adv     = s1_valid & s2_free;
    assign in_ready_o = !s1_valid | s1_adv;
    assign accept     = in_valid_i & in_ready_o & !flush_i;
    assign s1_load    = accept & !fuse_hit;

    mul #(.W(XLEN), .TYP(MUL_TYP)) u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (p)
    );

    assign r_full = s1_neg ? -p : p;

`ifdef MUL_HILO_FUSE_EN
    logic              tag_valid, tag_sa, tag_sb;
    logic [XLEN-1:0]   tag_rs1, tag_rs2, s1_rs1, s1_rs2;
    logic              s1_sa, s1_sb;
    logic [2*XLEN-1:0] tag_r;

    // Only with S1 empty, so the fused MUL cannot overtake an older op.
    assign fuse_hit = accept & (op_i == 2'b00) & !s1_valid & s2_free & tag_valid &
                      (tag_rs1 == rs1_i) & (tag_rs2 == rs2_i) &
                      (tag_sa == sa_in) & (tag_sb == sb_in);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid <= 1'b0;
            tag_sa    <= 1'b0;
            tag_sb    <= 1'b0;
            tag_rs1   <= '0;
            tag_rs2   <= '0;
            tag_r     <= '0;
        end else if (flush_i || fuse_hit) begin
            tag_valid <= 1'b0;
        end else if (s1_adv) begin
            tag_valid <= s1_hi;
            tag_sa    <= s1_sa;
            tag_sb    <= s1_sb;
            tag_rs1   <= s1_rs1;
            tag_rs2   <= s1_rs2;
            tag_r     <= r_full;
        end
    end
`else
    assign fuse_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_hi    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
`ifdef MUL_HILO_FUSE_EN
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
`endif
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_a   <= a_mag;
                s1_b   <= b_mag;
                s1_neg <= sa_in ^ sb_in;
                s1_hi  <= (op_i != 2'b00);
`ifdef MUL_HILO_FUSE_EN
                s1_rs1 <= rs1_i;
                s1_rs2 <= rs2_i;
                s1_sa  <= sa_in;
                s1_sb  <= sb_in;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (s2_free) begin
            out_valid_o <= s1_valid | fuse_hit;
            if (s1_valid) begin
                result_o <= s1_hi ? r_full[2*XLEN-1:XLEN] : r_full[XLEN-1:0];
            end
`ifdef MUL_HILO_FUSE_EN
            else if (fuse_hit) begin
                result_o <= tag_r[XLEN-1:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Scoreboard bench for mul_pipe_ctrl: expected words come from plain 64-bit arithmetic,
// a negedge monitor pops and compares on every output handshake.

module tb_mul_pipe_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        in_ready, out_valid;
    logic [31:0] result;

    int          checks = 0, failures = 0, delivered = 0;
    logic [31:0] expq[$];
    logic        prev_stall = 1'b0, saw_not_ready = 1'b0;
    logic [31:0] prev_res = '0;

    always #5 clk = ~clk;

    mul_pipe_ctrl #(.XLEN(32), .MUL_TYP(0)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result)
    );

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, prod;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (o)
            2'b00:   begin prod = ua * ub; return prod[31:0];  end
            2'b01:   begin prod = sa * sb; return prod[63:32]; end
            2'b10:   begin prod = sa * ub; return prod[63:32]; end
            default: begin prod = ua * ub; return prod[63:32]; end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_result", result, prev_res);
            end
            if (!in_ready) saw_not_ready = 1'b1;
            if (out_valid && out_ready) begin
                delivered++;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %h expected none", result);
                end else begin
                    chk("result", result, expq.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_res   = result;
            if (flush) expq.delete();
            else if (in_valid && in_ready) expq.push_back(model(op, rs1, rs2));
        end
    end

    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic acc;
        int   n;
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
    endtask

    // Issue one op into an idle unit and count clock edges until out_valid_o rises.
    task automatic lat_check(input string name, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        wait_empty();
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_lat"}, n, lat);
        chk(name, result, exp);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c[5];
        c = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(3) == 0) return c[$urandom_range(4)];
        return $urandom;
    endfunction

    int fuse_lat;
    int base;

    initial begin
`ifdef MUL_HILO_FUSE_EN
        fuse_lat = 1;
`else
        fuse_lat = 2;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_check("mul_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 2);
        lat_check("mulh_neg3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 2);
        lat_check("mulhu_fffffffd_x5", 2'b11, 32'hFFFFFFFD, 32'd5, 32'h00000004, 2);
        lat_check("mulhsu_m1xffffffff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        lat_check("mulh_min_sq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 2);
        lat_check("mul_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 2);

        lat_check("fuse_mulh_7x9", 2'b01, 32'd7, 32'd9, 32'h0, 2);
        lat_check("fuse_mul_7x9", 2'b00, 32'd7, 32'd9, 32'h3F, fuse_lat);
        lat_check("nofuse_mulhu", 2'b11, 32'hFFFFFFFF, 32'd3, 32'h2, 2);
        lat_check("nofuse_mul", 2'b00, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 2);
        wait_empty();

        // Eight back-to-back ops with a 3-cycle downstream stall in the middle.
        saw_not_ready = 1'b0;
        base = delivered;
        fork
            for (int i = 0; i < 8; i++) send(2'($urandom_range(3)), pick(), pick());
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();
        chk("stall_in_ready_dropped", {31'b0, saw_not_ready}, 32'd1);
        chk("stall_delivered", delivered - base, 32'd8);

        // Flush with both stages occupied.
        out_ready = 1'b0;
        send(2'b01, 32'd123, 32'd456);
        send(2'b00, 32'd789, 32'd1011);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_stale", {31'b0, out_valid}, 32'd0);

        // Reset pulse mid-stream.
        out_ready = 1'b0;
        send(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
        send(2'b10, 32'h12345678, 32'h9ABCDEF0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_stale", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);

        // Random traffic; repeated operands exercise fusion when it is built in.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            op        = 2'($urandom_range(3));
            if ($urandom_range(2) != 0) begin
                rs1 = pick();
                rs2 = pick();
            end
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(49) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        wait_empty();
        chk("final_queue_empty", expq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
